dvp_pattern_tx: RTL

- Emits camera-side DVP timing on the pixel clock: `cmos_vsync`, `cmos_href` and an 8-bit data bus in YUYV byte order.
- Stands in for the CMOS sensor, so the capture path and the on-chip analyzer probes on vsync/href/cam_y can be exercised without a camera.
- Generates programmable synthetic luma patterns with a fixed chroma value.
- Sits in the pixel-clock domain and feeds the DVP receiver through a mux in place of the sensor pads.

---
 rtl/dvp_pkg.sv | 25 ++
 rtl/dvp_pattern_lut.sv | 23 ++
 rtl/dvp_pattern_tx.sv | 122 ++++++++++++
 3 files changed

// File: rtl/dvp_pkg.sv
// Shared types for the DVP pattern transmitter and the matching receive-side checker.
package dvp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        VSYNC,
        VBACK,
        ACTIVE,
        VFRONT
    } state_e;

    typedef enum logic [1:0] {
        MODE_HRAMP = 2'd0,
        MODE_VRAMP = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_FRAME = 2'd3
    } mode_e;

    localparam int BYTES_PER_PIX = 2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/dvp_pattern_lut.sv
// Synthetic luma generator: Y as a pure function of pattern mode, pixel position and frame count.
module dvp_pattern_lut
    import dvp_pkg::*;
(
    input  mode_e      mode,
    input  logic [7:0] x,
    input  logic [7:0] y,
    input  logic [7:0] frame_cnt,
    output logic [7:0] luma
);

    always_comb begin
        luma = 8'h00;
        unique case (mode)
            MODE_HRAMP: luma = x;
            MODE_VRAMP: luma = y;
            MODE_CHECK: luma = (x[3] ^ y[3]) ? 8'hFF : 8'h00;
            MODE_FRAME: luma = frame_cnt;
            default:    luma = 8'h00;
        endcase
    end

endmodule

// File: rtl/dvp_pattern_tx.sv
// Camera-side DVP timing generator (vsync/href/YUYV bytes) standing in for the CMOS sensor.
module dvp_pattern_tx
    import dvp_pkg::*;
#(
    parameter int         H_ACTIVE      = 640,
    parameter int         H_BLANK       = 144,
    parameter int         V_ACTIVE      = 480,
    parameter int         VSYNC_LINES   = 3,
    parameter int         V_BACK_LINES  = 17,
    parameter int         V_FRONT_LINES = 10,
    parameter bit         VSYNC_POL     = 1'b1,
    parameter logic [7:0] CHROMA        = 8'h80
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [1:0] mode_i,
    output logic       cmos_vsync,
    output logic       cmos_href,
    output logic [7:0] cmos_data,
    output logic       frame_done_o,
    output logic       busy_o
);

    localparam int HREF_END   = BYTES_PER_PIX * H_ACTIVE;
    localparam int LINE_TOTAL = HREF_END + H_BLANK;
    localparam int MAX_LINES  = max2(max2(VSYNC_LINES, V_BACK_LINES), max2(V_ACTIVE, V_FRONT_LINES));
    localparam int HCNT_W     = $clog2(LINE_TOTAL);
    localparam int LCNT_W     = $clog2(MAX_LINES + 1);

    function automatic int lines_in(input state_e s);
        case (s)
            VSYNC:   return VSYNC_LINES;
            VBACK:   return V_BACK_LINES;
            ACTIVE:  return V_ACTIVE;
            VFRONT:  return V_FRONT_LINES;
            default: return 1;
        endcase
    endfunction

    state_e              state_q, state_d;
    logic [HCNT_W-1:0]   hcnt_q;
    logic [LCNT_W-1:0]   lcnt_q;
    logic [7:0]          frame_cnt_q;
    mode_e               mode_q;
    logic                line_end, state_end, frame_end;

    logic                vsync_p0, href_p0, done_p0, busy_p0;
    logic [7:0]          data_p0, luma_p0;

    assign line_end  = (hcnt_q == HCNT_W'(LINE_TOTAL - 1));
    assign state_end = line_end && (int'(lcnt_q) == lines_in(state_q) - 1);
    // With no front porch the frame closes on the last active line.
    assign frame_end = state_end &&
                       ((state_q == VFRONT) || ((V_FRONT_LINES == 0) && (state_q == ACTIVE)));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   if (enable_i) state_d = VSYNC;
            VSYNC:  if (state_end) state_d = (V_BACK_LINES != 0) ? VBACK : ACTIVE;
            VBACK:  if (state_end) state_d = ACTIVE;
            ACTIVE: if (state_end) begin
                if (V_FRONT_LINES != 0) state_d = VFRONT;
                else                    state_d = enable_i ? VSYNC : IDLE;
            end
            VFRONT: if (state_end) state_d = enable_i ? VSYNC : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            lcnt_q      <= '0;
            frame_cnt_q <= '0;
            mode_q      <= MODE_HRAMP;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE || line_end) hcnt_q <= '0;
            else                             hcnt_q <= hcnt_q + HCNT_W'(1);
            if (state_d != state_q) lcnt_q <= '0;
            else if (line_end)      lcnt_q <= lcnt_q + LCNT_W'(1);
            if (frame_end) frame_cnt_q <= frame_cnt_q + 8'd1;
            if (state_d == VSYNC && state_q != VSYNC) mode_q <= mode_e'(mode_i);
        end
    end

    dvp_pattern_lut u_lut (
        .mode      (mode_q),
        .x         (8'(hcnt_q >> 1)),
        .y         (8'(lcnt_q)),
        .frame_cnt (frame_cnt_q),
        .luma      (luma_p0)
    );

    // p0: output values decoded from the current FSM/counter state
    assign vsync_p0 = (state_q == VSYNC) ? VSYNC_POL : ~VSYNC_POL;
    assign href_p0  = (state_q == ACTIVE) && (hcnt_q < HCNT_W'(HREF_END));
    assign data_p0  = href_p0 ? (hcnt_q[0] ? CHROMA : luma_p0) : 8'h00;
    assign done_p0  = frame_end;
    assign busy_p0  = (state_q != IDLE);

    // p1: registered pad outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmos_vsync   <= ~VSYNC_POL;
            cmos_href    <= 1'b0;
            cmos_data    <= 8'h00;
            frame_done_o <= 1'b0;
            busy_o       <= 1'b0;
        end else begin
            cmos_vsync   <= vsync_p0;
            cmos_href    <= href_p0;
            cmos_data    <= data_p0;
            frame_done_o <= done_p0;
            busy_o       <= busy_p0;
        end
    end

endmodule
